// File: rtl/fab_clk_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fab_clk_tick_gen                                             |
// | Description : Fabric timebase. Synchronised, stretched fabric reset plus   |
// |               1 us / 1 ms tick enables, heartbeat toggle and a millisecond |
// |               uptime counter, all derived from FAB_CLK.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fab_clk_tick_gen #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int HOLD_CYCLES  = 1024,
  parameter int HEARTBEAT_MS = 500
) (
  input  logic        FAB_CLK,
  input  logic        M2F_RESET_N,
  input  logic        TICK_EN,
  output logic        FAB_RESET_N,
  output logic        TICK_US,
  output logic        TICK_MS,
  output logic        HEARTBEAT,
  output logic [31:0] UPTIME_MS,
  output logic [1:0]  STATE
);

  // Derived constants and counter widths
  localparam int US_DIV = CLK_HZ / 1_000_000;
  localparam int US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int HB_W   = (HEARTBEAT_MS > 1) ? $clog2(HEARTBEAT_MS) : 1;
  localparam int MS_W   = 10;

  localparam logic [US_W-1:0]   US_LAST   = US_W'(US_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HEARTBEAT_MS - 1);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(999);

  // Elaboration-time parameter legality checks
  generate
    if ((CLK_HZ < 2_000_000) || ((CLK_HZ % 1_000_000) != 0)) begin : g_bad_clk_hz
      $error("fab_clk_tick_gen: CLK_HZ must be a multiple of 1_000_000 and >= 2_000_000");
    end
    if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 65535)) begin : g_bad_hold
      $error("fab_clk_tick_gen: HOLD_CYCLES must be in 1..65535");
    end
    if ((HEARTBEAT_MS < 1) || (HEARTBEAT_MS > 65535)) begin : g_bad_heartbeat
      $error("fab_clk_tick_gen: HEARTBEAT_MS must be in 1..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_SYNC  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              sync1;
  logic              sync2;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              fab_reset_n;
  logic [US_W-1:0]   us_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic [HB_W-1:0]   hb_cnt;
  logic              tick_us;
  logic              tick_ms;
  logic              heartbeat;
  logic [31:0]       uptime;
  logic              run_en;
  logic              us_wrap;
  logic              ms_wrap;

  // Two-flop reset synchroniser: asserts asynchronously, releases on the clock
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= 1'b1;
      sync2 <= sync1;
    end
  end

  // State register
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) state <= ST_RESET;
    else              state <= state_next;
  end

  assign hold_done = (state == ST_HOLD) && (hold_cnt == HOLD_LAST);

  // Next-state logic: RESET -> SYNC -> HOLD -> RUN, RUN is terminal
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: state_next = ST_SYNC;
      ST_SYNC:  if (sync2) state_next = ST_HOLD;
      ST_HOLD:  if (hold_done) state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_RESET;
    endcase
  end

  // Hold counter and registered fabric reset release at terminal count
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      hold_cnt    <= '0;
      fab_reset_n <= 1'b0;
    end else if (state == ST_HOLD) begin
      if (hold_done) fab_reset_n <= 1'b1;
      else           hold_cnt    <= hold_cnt + 1'b1;
    end
  end

  // Prescalers only advance in RUN with the enable high; TICK_MS coincides
  // with every 1000th TICK_US because both are registered from the same edge
  assign run_en  = (state == ST_RUN) && TICK_EN;
  assign us_wrap = run_en && (us_cnt == US_LAST);
  assign ms_wrap = us_wrap && (ms_cnt == MS_LAST);

  // us and ms prescalers with registered tick pulses
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      us_cnt  <= '0;
      ms_cnt  <= '0;
      tick_us <= 1'b0;
      tick_ms <= 1'b0;
    end else begin
      tick_us <= us_wrap;
      tick_ms <= ms_wrap;
      if (run_en) us_cnt <= us_wrap ? '0 : us_cnt + 1'b1;
      if (us_wrap) ms_cnt <= ms_wrap ? '0 : ms_cnt + 1'b1;
    end
  end

  // Heartbeat divider and uptime counter, both advanced by the ms tick
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
      uptime    <= '0;
    end else if (tick_ms) begin
      uptime <= uptime + 32'd1;
      if (hb_cnt == HB_LAST) begin
        hb_cnt    <= '0;
        heartbeat <= ~heartbeat;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  assign FAB_RESET_N = fab_reset_n;
  assign TICK_US     = tick_us;
  assign TICK_MS     = tick_ms;
  assign HEARTBEAT   = heartbeat;
  assign UPTIME_MS   = uptime;
  assign STATE       = state;

endmodule
`default_nettype wire

// File: tb/tb_fab_clk_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fab_clk_tick_gen                                          |
// | Description : Directed bench for fab_clk_tick_gen (4 MHz, hold 8, hb 2).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fab_clk_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick_en = 1'b1;
  logic        fab_reset_n;
  logic        tick_us;
  logic        tick_ms;
  logic        heartbeat;
  logic [31:0] uptime_ms;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  fab_clk_tick_gen #(
    .CLK_HZ      (4_000_000),
    .HOLD_CYCLES (8),
    .HEARTBEAT_MS(2)
  ) dut (
    .FAB_CLK    (clk),
    .M2F_RESET_N(rst_n),
    .TICK_EN    (tick_en),
    .FAB_RESET_N(fab_reset_n),
    .TICK_US    (tick_us),
    .TICK_MS    (tick_ms),
    .HEARTBEAT  (heartbeat),
    .UPTIME_MS  (uptime_ms),
    .STATE      (state)
  );

  // 100 MHz simulation clock
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [1:0]  st;
    logic        fab;
    logic        tus;
    logic        tms;
    logic        hb;
    logic [31:0] up;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic r, input logic e, input logic [1:0] s,
                              input logic f, input logic tu);
    vec_t v;
    v.rst_n = r; v.en = e; v.st = s; v.fab = f; v.tus = tu;
    v.tms = 1'b0; v.hb = 1'b0; v.up = 32'd0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Step until TICK_MS is seen or the bound expires; returns edge number or -1
  task automatic wait_tick_ms(input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      step();
      if (tick_ms) begin
        at = edge_n;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_us, last_ms, n_us, n_ms, n_hb, us_bad, ms_bad, hb_bad, orphan, first_ms;
    int gap_bad, at;
    logic hb_prev;

    // Table: 3 cycles in reset, then edges 1..16 after release
    for (int i = 0; i < 3; i++) vecs[i] = mk(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    vecs[3] = mk(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);   // edge 1: SYNC
    vecs[4] = mk(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);   // edge 2: sync out = 1
    for (int i = 5; i < 13; i++) vecs[i] = mk(1'b1, 1'b1, 2'd2, 1'b0, 1'b0); // edges 3..10 HOLD
    vecs[13] = mk(1'b1, 1'b1, 2'd3, 1'b1, 1'b0);  // edge 11: RUN, reset released
    for (int i = 14; i < 17; i++) vecs[i] = mk(1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
    vecs[17] = mk(1'b1, 1'b1, 2'd3, 1'b1, 1'b1);  // edge 15: first TICK_US
    vecs[18] = mk(1'b1, 1'b1, 2'd3, 1'b1, 1'b0);

    #2 rst_n = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst_n   = vecs[i].rst_n;
      tick_en = vecs[i].en;
      @(posedge clk);
      #1;
      if (rst_n) edge_n++;
      check($sformatf("vec%0d_flags", i),
            {26'd0, state, fab_reset_n, tick_us, tick_ms, heartbeat},
            {26'd0, vecs[i].st, vecs[i].fab, vecs[i].tus, vecs[i].tms, vecs[i].hb});
      check($sformatf("vec%0d_uptime", i), uptime_ms, vecs[i].up);
    end

    // 12 ms run: spacing of ticks, heartbeat toggles, uptime
    last_us = 15; last_ms = 0; n_us = 1; n_ms = 0; n_hb = 0;
    us_bad = 0; ms_bad = 0; hb_bad = 0; orphan = 0; first_ms = 0; hb_prev = 1'b0;
    while (edge_n < 48012) begin
      step();
      if (tick_us) begin
        if (edge_n - last_us != 4) us_bad++;
        last_us = edge_n;
        n_us++;
      end
      if (tick_ms) begin
        if (!tick_us) orphan++;
        if (n_ms == 0) first_ms = edge_n;
        else if (edge_n - last_ms != 4000) ms_bad++;
        last_ms = edge_n;
        n_ms++;
      end
      if (heartbeat != hb_prev) begin
        if (edge_n != 8012 + 8000 * n_hb) hb_bad++;
        n_hb++;
        hb_prev = heartbeat;
      end
    end
    check("us_spacing_errors", us_bad, 0);
    check("ms_spacing_errors", ms_bad, 0);
    check("ms_without_us", orphan, 0);
    check("first_tick_ms_edge", first_ms, 4011);
    check("tick_us_count", n_us, 12000);
    check("tick_ms_count", n_ms, 12);
    check("hb_toggle_count", n_hb, 6);
    check("hb_toggle_timing", hb_bad, 0);
    check("uptime_12ms", uptime_ms, 12);
    check("hb_after_12ms", {31'd0, heartbeat}, 0);

    // Enable gap of 37 cycles, one cycle into a microsecond
    tick_en = 1'b0;
    gap_bad = 0;
    for (int k = 0; k < 37; k++) begin
      step();
      if (tick_us || tick_ms || uptime_ms != 32'd12 || heartbeat != 1'b0) gap_bad++;
    end
    tick_en = 1'b1;
    check("gap_quiet", gap_bad, 0);
    at = -1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (tick_us) begin
        at = edge_n;
        break;
      end
    end
    check("tick_us_after_gap", at, 48052);
    wait_tick_ms(5000, at);
    check("tick_ms_after_gap", at, 52048);
    step();
    check("uptime_13ms", uptime_ms, 13);

    // Uptime wrap from all-ones
    force dut.uptime = 32'hFFFF_FFFF;
    #1 release dut.uptime;
    wait_tick_ms(5000, at);
    check("wrap_tick_ms_edge", at, 56048);
    step();
    check("uptime_wrap", uptime_ms, 0);
    check("hb_after_14ms", {31'd0, heartbeat}, 1);
    wait_tick_ms(5000, at);
    step();
    check("uptime_after_wrap", uptime_ms, 1);

    // 1 ns reset glitch mid-cycle during RUN
    #2 rst_n = 1'b0;
    #0.5;
    check("glitch_clear_flags", {26'd0, state, fab_reset_n, tick_us, tick_ms, heartbeat}, 0);
    check("glitch_clear_uptime", uptime_ms, 0);
    #0.5 rst_n = 1'b1;
    edge_n = 0;
    step();
    check("reseq_edge1_state", state, 1);
    step();
    step();
    check("reseq_edge3_state", state, 2);
    for (int k = 0; k < 7; k++) step();
    check("reseq_edge10_fab", {31'd0, fab_reset_n}, 0);
    step();
    check("reseq_edge11_fab", {31'd0, fab_reset_n}, 1);
    check("reseq_edge11_state", state, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fab_clk_tick_gen.md
# fab_clk_tick_gen

Fabric-side timebase directly downstream of the MSS clock conditioning stage. Consumes the RCOSC-derived `FAB_CLK` and the MSS fabric reset. Produces a synchronized, delayed fabric reset, 1 µs and 1 ms single-cycle tick enables, a heartbeat toggle and a free-running millisecond uptime counter for the rest of the websuit fabric logic.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, `FAB_CLK` frequency in Hz. Must be an integer multiple of 1_000_000 and ≥ 2_000_000; any other value is an elaboration error.
- `HOLD_CYCLES`, 1024, number of `FAB_CLK` cycles `FAB_RESET_N` is held low after the synchronizer releases. Range 1..65535.
- `HEARTBEAT_MS`, 500, number of ms ticks between `HEARTBEAT` toggles. Range 1..65535.

Ports:
- `FAB_CLK` in 1: sole clock. All logic is rising-edge.
- `M2F_RESET_N` in 1: asynchronous, active-low reset from the MSS.
- `TICK_EN` in 1: synchronous enable for prescalers, ticks, heartbeat and uptime.
- `FAB_RESET_N` out 1: fabric reset. Asserts asynchronously and deasserts synchronously after the hold period.
- `TICK_US` out 1: one-cycle pulse, once per µs.
- `TICK_MS` out 1: one-cycle pulse, once per ms.
- `HEARTBEAT` out 1: toggles every `HEARTBEAT_MS` ms.
- `UPTIME_MS` out 32: ms ticks since entering RUN.
- `STATE` out 2: current state, encoded 0=RESET, 1=SYNC, 2=HOLD, 3=RUN.

## Operation
- Derived constant: `US_DIV = CLK_HZ/1_000_000`. Counter widths are sized from the parameters.
- Reset values, all applied asynchronously while `M2F_RESET_N`=0:
  - `FAB_RESET_N`=0, `TICK_US`=0, `TICK_MS`=0, `HEARTBEAT`=0, `UPTIME_MS`=0, `STATE`=0.
  - All internal counters and synchronizer flops are also 0.
- Reset synchronizer: two flops, D input tied to 1, async-cleared by `M2F_RESET_N`.
- State machine:
  - RESET → SYNC on the first edge after `M2F_RESET_N` deasserts.
  - SYNC → HOLD when the synchronizer output is 1.
  - HOLD: the hold counter counts 0..`HOLD_CYCLES`-1. On terminal count, go to RUN and set `FAB_RESET_N`=1 (registered).
  - RUN is terminal until the next reset.
- Prescalers run only when `STATE`=RUN and `TICK_EN`=1:
  - µs counter runs 0..`US_DIV`-1. `TICK_US`=1 in the cycle after it reaches `US_DIV`-1, then the counter wraps to 0.
  - ms counter counts `TICK_US` pulses 0..999. `TICK_MS` asserts in the same cycle as every 1000th `TICK_US`.
  - Heartbeat counter counts `TICK_MS` pulses. `HEARTBEAT` inverts in the cycle after the `HEARTBEAT_MS`-th pulse, then the counter clears.
  - `UPTIME_MS` increments by 1 in the cycle after each `TICK_MS`. It wraps 0xFFFF_FFFF → 0 with no flag.
- When `TICK_EN`=0 in RUN:
  - All counters hold their value, `TICK_US`/`TICK_MS` stay 0, `HEARTBEAT` and `UPTIME_MS` hold.
  - On re-enable, counting resumes from the held values, so the phase is preserved.
- Reset mid-operation: an `M2F_RESET_N` low pulse of any length, including a glitch shorter than one clock, forces full reset state immediately. The block then re-runs SYNC and HOLD.
- `TICK_EN` is ignored outside RUN. Ticks never assert while `FAB_RESET_N`=0.

## Timing
- Edge numbering: edge 1 is the first `FAB_CLK` rising edge with `M2F_RESET_N`=1.
  - After edge 1: `STATE`=SYNC.
  - After edge 2: synchronizer output = 1.
  - After edge 3: `STATE`=HOLD, hold counter = 0.
  - After edge 3+`HOLD_CYCLES`: `STATE`=RUN and `FAB_RESET_N`=1.
- First `TICK_US` pulse: `US_DIV` cycles after the first RUN cycle that has `TICK_EN`=1.
- Tick spacing with `TICK_EN` held at 1:
  - `TICK_US` exactly every `US_DIV` cycles.
  - `TICK_MS` every 1000·`US_DIV` cycles.
  - `HEARTBEAT` period 2·`HEARTBEAT_MS` ms.
- Each cycle with `TICK_EN`=0 delays all subsequent ticks by exactly one cycle.
- All outputs are registered. No output has a combinational path from any input.
- Reset assertion is asynchronous: outputs reach their reset values within the flop clear-to-Q delay, with no clock required.

## Test plan
- Test parameters: `CLK_HZ`=4_000_000, `HOLD_CYCLES`=8, `HEARTBEAT_MS`=2, `TICK_EN`=1.
  - Release reset → `FAB_RESET_N` rises after edge 11, `STATE` goes 0,1,2,3.
  - First `TICK_US` appears 4 cycles after RUN is entered.
- Same parameters, run 12 ms:
  - `TICK_US` every 4 cycles and `TICK_MS` every 4000 cycles, each 1 cycle wide.
  - `HEARTBEAT` toggles every 8000 cycles.
  - `UPTIME_MS`=12.
- Drop `TICK_EN` for 37 cycles mid-µs → no ticks during the gap. The next `TICK_US` arrives exactly 37 cycles later than it would have, and all counters are unchanged across the gap.
- 1-ns `M2F_RESET_N` glitch during RUN → all outputs clear immediately, including `UPTIME_MS`=0 and `HEARTBEAT`=0. The full SYNC and HOLD sequence repeats, with `FAB_RESET_N` high 11 edges after the glitch.
- Force `UPTIME_MS` to 0xFFFF_FFFF, then apply one `TICK_MS` → `UPTIME_MS`=0, and the block continues counting.
- `CLK_HZ`=1_500_000 → elaboration fails with a parameter error.
